caesar_decrypt_stream: RTL
==========================

// Module: caesar_decrypt_stream
// PURPOSE
//  Receive-side inverse of the team's Caesar/XOR encryptor: plain = (cipher ^ key) - OFFSET, mod 256.
//  Streaming 2-stage pipeline with valid/ready handshakes on both sides and frame framing via *_last.
//  Key is latched per frame. Sits between the link receive path and the plaintext consumer.
// PARAMETERS
//  OFFSET   3   shift subtracted after XOR; must equal the encryptor's OFFSET (0..255)
// PORTS
//  clk         in   1   single clock, rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  key         in   8   decryption key; sampled only on the first beat of a frame
//  s_valid     in   1   cipher beat valid
//  s_ready     out  1   block can accept a cipher beat
//  s_data      in   8   cipher byte
//  s_last      in   1   final beat of the frame
//  m_valid     out  1   plaintext beat valid
//  m_ready     in   1   consumer accepts the plaintext beat
//  m_data      out  8   plaintext byte
//  m_last      out  1   s_last carried through the pipeline
//  busy        out  1   frame open (FRAME state) or any pipeline stage holds a beat
//  frame_cnt   out  16  completed output frames; wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset (async assert, sync deassert upstream): m_valid=0, m_data=0, m_last=0, busy=0, frame_cnt=0.
//    Stage valids clear, key_q=0, FSM=IDLE. s_ready=1 after reset.
//    A partial frame in flight at reset is discarded; no beats are emitted for it.
//  - Handshake: transfer occurs when valid&&ready are high on a rising clk.
//    While m_valid=1 && m_ready=0, m_data and m_last hold stable.
//  - Readiness: rdy2 = !v2 | m_ready; rdy1 = !v1 | rdy2; s_ready = rdy1.
//    Combinational ready chain gives full throughput of 1 beat/cycle.
//  - Stage 1: x1 <= s_data ^ k_cur, last1 <= s_last, on accept.
//  - Stage 2: m_data <= x1 - OFFSET, modulo 256 (8-bit wrap; 0x01-3 = 0xFE). m_last <= last1.
//  - Latency: accepted beat appears on m_* exactly 2 cycles later when m_ready is held high.
//  - FSM IDLE/FRAME:
//    - IDLE: k_cur = key (live). On accept, key_q <= key; go to FRAME if !s_last, else stay in IDLE.
//    - FRAME: k_cur = key_q. Changes on key are ignored. On accept with s_last, go to IDLE.
//    - A single-beat frame (s_last on the first beat) never enters FRAME.
//  - frame_cnt increments on m_valid && m_ready && m_last.
//  - Simultaneous accept at input and output in the same cycle is legal; pipeline shifts with no bubble.
//  - s_valid without s_ready: beat not taken; upstream must hold it.
// CONFIGURATION
//  CAESAR_ROLLING_KEY_EN defined:
//    - k_cur on beat n of a frame = key + n, mod 256. Beat 0 uses key.
//    - key_q increments on every accepted non-first beat.
//    - Pairs only with an encryptor built with the same macro.
//  CAESAR_ROLLING_KEY_EN undefined: key is constant for the whole frame, as above.
// STRUCTURE
//  - caesar_pkg holds:
//    - CAESAR_OFFSET_DEFAULT = 3
//    - typedef of the FSM enum {IDLE, FRAME}
//    - function caesar_dec_byte(cipher, key, offset)
//    - byte_t typedef (8-bit)
//  - Sub-module caesar_pipe_stage: one valid/ready register slice (data+last).
//    Instantiated twice; the XOR and subtract logic sit between the instances.
//  - Top level holds the FSM, key_q, frame_cnt and busy.
// TESTING
//  1. Single-beat frame: OFFSET=3, key=0x5A, s_data=0x1E, s_last=1, m_ready=1
//     -> m_data=0x41, m_last=1 at +2 cycles; frame_cnt=1.
//  2. Wrap: key=0x00, s_data=0x01 -> m_data=0xFE.
//     Also key=0xFF, s_data=0xFC (plain 0x00) -> m_data=0x00.
//  3. Key latch: 4-beat frame, key=0x5A on beat 0, key changed to 0x11 on beats 1-3
//     -> all beats decoded with 0x5A.
//     Next frame uses 0x11. With ROLLING_EN: beats use 0x5A..0x5D.
//  4. Backpressure: stream of 8 beats, m_ready low for 3 cycles mid-stream
//     -> s_ready drops after two stages fill; m_data stable while stalled.
//     No loss or duplication; order preserved.
//  5. Throughput: s_valid and m_ready continuously high for 256 beats
//     -> one m beat per cycle after 2-cycle fill.
//  6. Reset mid-frame: assert rst_n=0 after beat 2 of 5
//     -> m_valid=0 and busy=0 immediately; frame_cnt=0.
//     Next frame latches a fresh key and decodes correctly.

Source files
------------

// File: rtl/caesar_pkg.sv
// Shared types and helpers for the Caesar/XOR stream decryptor.
// Decode rule: plain = (cipher ^ key) - offset, modulo 256.
package caesar_pkg;

    localparam int unsigned CAESAR_OFFSET_DEFAULT = 3;

    typedef logic [7:0] byte_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } caesar_state_e;

    function automatic byte_t caesar_dec_byte(input byte_t cipher, input byte_t key, input byte_t offset);
        return byte_t'((cipher ^ key) - offset);
    endfunction

endpackage

// File: rtl/caesar_pipe_stage.sv
// One valid/ready register slice carrying a byte and its last flag.
// Handshake: a beat moves when valid && ready on a rising clk; a held beat stays stable until taken.
module caesar_pipe_stage
    import caesar_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  s_valid,
    output logic  s_ready,
    input  byte_t s_data,
    input  logic  s_last,
    output logic  m_valid,
    input  logic  m_ready,
    output byte_t m_data,
    output logic  m_last
);

    // Empty, or the held beat leaves this cycle.
    assign s_ready = !m_valid || m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (s_ready) begin
            m_valid <= s_valid;
            if (s_valid) begin
                m_data <= s_data;
                m_last <= s_last;
            end
        end
    end

endmodule

// File: rtl/caesar_decrypt_stream.sv
// Two-stage streaming Caesar/XOR decryptor with per-frame key latching.
// Define CAESAR_ROLLING_KEY_EN to advance the key by one on every beat of a frame.
module caesar_decrypt_stream
    import caesar_pkg::*;
#(
    parameter int unsigned OFFSET = CAESAR_OFFSET_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  key,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        m_last,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam byte_t OFF = byte_t'(OFFSET);

    caesar_state_e state_q;
    byte_t         key_q;
    byte_t         k_frame;
    byte_t         k_cur;
    byte_t         x0;
    byte_t         x1;
    byte_t         d2;
    logic          v1;
    logic          last1;
    logic          rdy2;
    logic          accept;

    assign accept = s_valid && s_ready;

`ifdef CAESAR_ROLLING_KEY_EN
    // key_q holds the key of the previous beat, so the current beat uses one more.
    assign k_frame = key_q + 8'd1;
`else
    assign k_frame = key_q;
`endif

    assign k_cur = (state_q == IDLE) ? key : k_frame;
    assign x0    = s_data ^ k_cur;
    assign d2    = caesar_dec_byte(x1, 8'h00, OFF);

    caesar_pipe_stage u_stage1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (x0),
        .s_last  (s_last),
        .m_valid (v1),
        .m_ready (rdy2),
        .m_data  (x1),
        .m_last  (last1)
    );

    caesar_pipe_stage u_stage2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (v1),
        .s_ready (rdy2),
        .s_data  (d2),
        .s_last  (last1),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
        end else if (accept) begin
            if (state_q == IDLE) begin
                key_q <= key;
                if (!s_last) state_q <= FRAME;
            end else begin
`ifdef CAESAR_ROLLING_KEY_EN
                key_q <= k_frame;
`endif
                if (s_last) state_q <= IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (m_valid && m_ready && m_last) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign busy = (state_q == FRAME) || v1 || m_valid;

endmodule
